// File: rtl/pru_io_cmd_decoder.sv
// pru_io_cmd_decoder: host I/O command decoder for the DPU.
// Turns host opcodes into memory strobes and runs the execution handshake.
module pru_io_cmd_decoder #(
  parameter int IO_W   = 32,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        io_opcode,
  input  logic [IO_W-1:0]   in,
  input  logic              reset_execution_io,
  input  logic              enable_execution_io,
  output logic              done_execution_io,
  output logic [IO_W-1:0]   out,
  output logic              wr_en,
  output logic [1:0]        wr_target,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [IO_W-1:0]   wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [IO_W-1:0]   rd_data,
  output logic              core_reset,
  output logic              core_enable,
  input  logic              core_done
);

  localparam logic [3:0] OP_SET = 4'd1;
  localparam logic [3:0] OP_CFG = 4'd2;
  localparam logic [3:0] OP_DAT = 4'd3;
  localparam logic [3:0] OP_INS = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_en;
  logic [1:0]        r_wr_target;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [IO_W-1:0]   r_wr_data;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [RD_LAT-1:0] r_vld;
  logic [IO_W-1:0]   r_out;
  logic              r_core_reset;

  logic              w_run;
  logic              w_set;
  logic              w_wr;
  logic              w_rd;
  logic [1:0]        w_tgt;
  logic              w_core_enable;
  logic              w_done;

  // Memory access commands are blocked while the core owns the memories.
  assign w_run = (r_state == S_RUN);

  // Opcode decode; undefined codes fall through as NOP.
  always_comb begin
    w_set = 1'b0;
    w_wr  = 1'b0;
    w_rd  = 1'b0;
    w_tgt = 2'd0;
    case (io_opcode)
      OP_SET: w_set = 1'b1;
      OP_CFG: begin
        w_wr  = ~w_run;
        w_tgt = 2'd0;
      end
      OP_DAT: begin
        w_wr  = ~w_run;
        w_tgt = 2'd1;
      end
      OP_INS: begin
        w_wr  = ~w_run;
        w_tgt = 2'd2;
      end
      OP_RD:  w_rd = ~w_run;
      default: ;
    endcase
  end

  // Address pointer and registered write/read strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_target <= 2'd0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
    end else begin
      r_wr_en <= w_wr;
      r_rd_en <= w_rd;
      if (w_set) begin
        r_addr <= in[ADDR_W-1:0];
      end
      if (w_wr) begin
        r_wr_target <= w_tgt;
        r_wr_addr   <= r_addr;
        r_wr_data   <= in;
        r_addr      <= r_addr + 1'b1;
      end
      if (w_rd) begin
        r_rd_addr <= r_addr;
        r_addr    <= r_addr + 1'b1;
      end
    end
  end

  // Valid shift register follows each read through the memory latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= r_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // Capture returning read data; hold until the next read lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else if (r_vld[RD_LAT-1]) begin
      r_out <= rd_data;
    end
  end

  // Execution FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Execution FSM next state; host reset wins over enable.
  always_comb begin
    w_state_nxt = r_state;
    if (reset_execution_io) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (enable_execution_io) w_state_nxt = S_RUN;
        S_RUN:  if (core_done) w_state_nxt = S_DONE;
        S_DONE: w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Execution FSM outputs decoded from the current state.
  always_comb begin
    w_core_enable = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      S_RUN:  w_core_enable = 1'b1;
      S_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  // Core reset pulse in the cycle after a host reset request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_reset <= 1'b0;
    end else begin
      r_core_reset <= reset_execution_io;
    end
  end

  assign wr_en             = r_wr_en;
  assign wr_target         = r_wr_target;
  assign wr_addr           = r_wr_addr;
  assign wr_data           = r_wr_data;
  assign rd_en             = r_rd_en;
  assign rd_addr           = r_rd_addr;
  assign out               = r_out;
  assign core_reset        = r_core_reset;
  assign core_enable       = w_core_enable;
  assign done_execution_io = w_done;

endmodule
